// File: rtl/cmp_run_monitor_pkg.sv
// Shared definitions for the multi-core run monitor: FSM encoding, halt
// encoding default and an index-width helper.
package cmp_run_monitor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RUN       = 3'd1,
      ST_DRAIN     = 3'd2,
      ST_DUMP_RD   = 3'd3,
      ST_DUMP_WAIT = 3'd4,
      ST_DUMP_OUT  = 3'd5,
      ST_DONE      = 3'd6
   } state_t;

   localparam logic [31:0] HALT_WORD_DEFAULT = 32'h0000_0000;

   // Width needed to index n items; never below 1 so single-core builds stay legal.
   function automatic int idx_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/cmp_run_monitor_if.sv
// Data-memory read port and dump output stream of the run monitor.
interface cmp_run_monitor_if
   import cmp_run_monitor_pkg::*;
#(
   parameter int NUM_CORES  = 4,
   parameter int DATA_WIDTH = 64,
   parameter int DUMP_DEPTH = 128
);
   localparam int CW = idx_width(NUM_CORES);
   localparam int AW = idx_width(DUMP_DEPTH);

   logic                  dump_en;
   logic [CW-1:0]         dump_core;
   logic [AW-1:0]         dump_addr;
   logic [DATA_WIDTH-1:0] dump_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [CW-1:0]         out_core;
   logic [AW-1:0]         out_addr;
   logic [DATA_WIDTH-1:0] out_data;

   modport master (
      output dump_en, dump_core, dump_addr, out_valid, out_core, out_addr, out_data,
      input  dump_data, out_ready
   );

   modport slave (
      input  dump_en, dump_core, dump_addr, out_valid, out_core, out_addr, out_data,
      output dump_data, out_ready
   );
endinterface

// File: rtl/cmp_run_monitor_halt_tracker.sv
// One core's sticky halt flag and the cycle count captured when it halted.
module cmp_halt_tracker #(
   parameter int                    INST_WIDTH = 32,
   parameter int                    CYC_WIDTH  = 32,
   parameter logic [INST_WIDTH-1:0] HALT_WORD  = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  run,
   input  logic [INST_WIDTH-1:0] inst,
   input  logic                  inst_valid,
   input  logic [CYC_WIDTH-1:0]  cycle,
   output logic                  halted,
   output logic [CYC_WIDTH-1:0]  halt_cycle
);
   logic                 halted_reg;
   logic [CYC_WIDTH-1:0] halt_cycle_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         halted_reg     <= 1'b0;
         halt_cycle_reg <= '0;
      end else if (clear) begin
         halted_reg     <= 1'b0;
         halt_cycle_reg <= '0;
      end else if (run && !halted_reg && inst_valid && inst == HALT_WORD) begin
         halted_reg     <= 1'b1;
         halt_cycle_reg <= cycle;
      end
   end

   assign halted     = halted_reg;
   assign halt_cycle = halt_cycle_reg;
endmodule

// File: rtl/cmp_run_monitor.sv
// Run-control FSM: counts cycles until every core halts, drains, then
// streams each core's data memory out through a valid/ready port.
module cmp_run_monitor
   import cmp_run_monitor_pkg::*;
#(
   parameter int                    NUM_CORES    = 4,
   parameter int                    INST_WIDTH   = 32,
   parameter int                    DATA_WIDTH   = 64,
   parameter int                    DUMP_DEPTH   = 128,
   parameter int                    DRAIN_CYCLES = 5,
   parameter int                    CYC_WIDTH    = 32,
   parameter logic [INST_WIDTH-1:0] HALT_WORD    = INST_WIDTH'(HALT_WORD_DEFAULT)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic [NUM_CORES*INST_WIDTH-1:0] inst_in,
   input  logic [NUM_CORES-1:0]            inst_valid,
   cmp_run_monitor_if.master               bus,
   output logic [NUM_CORES-1:0]            halted,
   output logic [NUM_CORES*CYC_WIDTH-1:0]  halt_cycle,
   output logic [CYC_WIDTH-1:0]            total_cycles,
   output logic                            busy,
   output logic                            done
);
   localparam int CW = idx_width(NUM_CORES);
   localparam int AW = idx_width(DUMP_DEPTH);
   localparam int DW = idx_width(DRAIN_CYCLES + 1);
   localparam logic [CW-1:0] LAST_CORE  = CW'(NUM_CORES - 1);
   localparam logic [AW-1:0] LAST_ADDR  = AW'(DUMP_DEPTH - 1);
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);

   state_t                state_reg;
   logic [DW-1:0]         drain_reg;
   logic [CW-1:0]         core_reg;
   logic [AW-1:0]         addr_reg;
   logic [CYC_WIDTH-1:0]  total_reg;
   logic                  out_valid_reg;
   logic [CW-1:0]         out_core_reg;
   logic [AW-1:0]         out_addr_reg;
   logic [DATA_WIDTH-1:0] out_data_reg;
   logic                  clear;
   logic                  running;

   assign clear   = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
   assign running = (state_reg == ST_RUN);

   generate
      for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
         cmp_halt_tracker #(
            .INST_WIDTH (INST_WIDTH),
            .CYC_WIDTH  (CYC_WIDTH),
            .HALT_WORD  (HALT_WORD)
         ) u_tracker (
            .clk        (clk),
            .reset      (reset),
            .clear      (clear),
            .run        (running),
            .inst       (inst_in[gi*INST_WIDTH +: INST_WIDTH]),
            .inst_valid (inst_valid[gi]),
            .cycle      (total_reg),
            .halted     (halted[gi]),
            .halt_cycle (halt_cycle[gi*CYC_WIDTH +: CYC_WIDTH])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= ST_IDLE;
         drain_reg     <= '0;
         core_reg      <= '0;
         addr_reg      <= '0;
         total_reg     <= '0;
         out_valid_reg <= 1'b0;
         out_core_reg  <= '0;
         out_addr_reg  <= '0;
         out_data_reg  <= '0;
      end else begin
         case (state_reg)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  total_reg <= '0;
                  state_reg <= ST_RUN;
               end
            end
            ST_RUN: begin
               // The counter stops on the cycle the completed halt set is seen.
               if (&halted) begin
                  drain_reg <= DRAIN_LOAD;
                  state_reg <= ST_DRAIN;
               end else if (total_reg != '1) begin
                  total_reg <= total_reg + CYC_WIDTH'(1);
               end
            end
            ST_DRAIN: begin
               drain_reg <= drain_reg - DW'(1);
               if (drain_reg == DW'(1)) begin
                  core_reg  <= '0;
                  addr_reg  <= '0;
                  state_reg <= ST_DUMP_RD;
               end
            end
            ST_DUMP_RD: begin
               state_reg <= ST_DUMP_WAIT;
            end
            ST_DUMP_WAIT: begin
               out_data_reg  <= bus.dump_data;
               out_core_reg  <= core_reg;
               out_addr_reg  <= addr_reg;
               out_valid_reg <= 1'b1;
               state_reg     <= ST_DUMP_OUT;
            end
            ST_DUMP_OUT: begin
               if (bus.out_ready) begin
                  out_valid_reg <= 1'b0;
                  if (addr_reg == LAST_ADDR) begin
                     addr_reg <= '0;
                     if (core_reg == LAST_CORE) begin
                        state_reg <= ST_DONE;
                     end else begin
                        core_reg  <= core_reg + CW'(1);
                        state_reg <= ST_DUMP_RD;
                     end
                  end else begin
                     addr_reg  <= addr_reg + AW'(1);
                     state_reg <= ST_DUMP_RD;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.dump_en   = (state_reg == ST_DUMP_RD);
   assign bus.dump_core = core_reg;
   assign bus.dump_addr = addr_reg;
   assign bus.out_valid = out_valid_reg;
   assign bus.out_core  = out_core_reg;
   assign bus.out_addr  = out_addr_reg;
   assign bus.out_data  = out_data_reg;

   assign total_cycles = total_reg;
   assign busy = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
   assign done = (state_reg == ST_DONE);
endmodule

// File: tb/tb_cmp_run_monitor.sv
// Scoreboard bench: a 4-core/8-word instance and a 1-core/128-word instance
// with a 4-bit cycle counter; expected dump words are queued at run start.
module tb_cmp_run_monitor;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      int          core;
      int          addr;
      logic [63:0] data;
   } word_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] pat(input int c, input int a);
      return 64'hA5A5_0000_0000_0000 ^ (64'(c) << 32) ^ (64'(a) * 64'h0000_0000_0001_0001);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- instance A: 4 cores, 8 words, 32-bit counter
   logic         rst_a = 1'b0, start_a = 1'b0;
   logic [127:0] inst_a = '0;
   logic [3:0]   iv_a = '0;
   logic [3:0]   halted_a;
   logic [127:0] hc_a;
   logic [31:0]  tot_a;
   logic         busy_a, done_a;
   cmp_run_monitor_if #(.NUM_CORES(4), .DATA_WIDTH(64), .DUMP_DEPTH(8)) bus_a ();

   cmp_run_monitor #(.NUM_CORES(4), .INST_WIDTH(32), .DATA_WIDTH(64), .DUMP_DEPTH(8),
                     .DRAIN_CYCLES(5), .CYC_WIDTH(32)) dut_a (
      .clk(clk), .reset(rst_a), .start(start_a), .inst_in(inst_a), .inst_valid(iv_a),
      .bus(bus_a), .halted(halted_a), .halt_cycle(hc_a), .total_cycles(tot_a),
      .busy(busy_a), .done(done_a));

   // ---------------- instance B: 1 core, 128 words, 4-bit counter
   logic        rst_b = 1'b0, start_b = 1'b0;
   logic [31:0] inst_b = '0;
   logic [0:0]  iv_b = '0;
   logic [0:0]  halted_b;
   logic [3:0]  hc_b;
   logic [3:0]  tot_b;
   logic        busy_b, done_b;
   cmp_run_monitor_if #(.NUM_CORES(1), .DATA_WIDTH(64), .DUMP_DEPTH(128)) bus_b ();

   cmp_run_monitor #(.NUM_CORES(1), .INST_WIDTH(32), .DATA_WIDTH(64), .DUMP_DEPTH(128),
                     .DRAIN_CYCLES(5), .CYC_WIDTH(4)) dut_b (
      .clk(clk), .reset(rst_b), .start(start_b), .inst_in(inst_b), .inst_valid(iv_b),
      .bus(bus_b), .halted(halted_b), .halt_cycle(hc_b), .total_cycles(tot_b),
      .busy(busy_b), .done(done_b));

   // data memories: registered read, one cycle after dump_en
   always @(posedge clk) if (bus_a.dump_en) bus_a.dump_data <= pat(int'(bus_a.dump_core), int'(bus_a.dump_addr));
   always @(posedge clk) if (bus_b.dump_en) bus_b.dump_data <= pat(int'(bus_b.dump_core), int'(bus_b.dump_addr));

   word_t qa[$];
   word_t qb[$];
   word_t wa, wb;

   // ready driver for A: random toggling with a 20-cycle stall at core 0 addr 5
   bit a_rand = 1'b0;
   bit a_ready_const = 1'b0;
   bit stalled_once = 1'b0;
   int a_stall = 0;
   initial begin
      bus_a.out_ready = 1'b0;
      forever begin
         tick();
         if (a_stall > 0) begin
            bus_a.out_ready = 1'b0;
            a_stall--;
         end else if (a_rand && !stalled_once && bus_a.out_valid &&
                      bus_a.out_core == 2'd0 && bus_a.out_addr == 3'd5) begin
            stalled_once = 1'b1;
            a_stall = 19;
            bus_a.out_ready = 1'b0;
         end else begin
            bus_a.out_ready = a_rand ? 1'($urandom_range(0, 1)) : a_ready_const;
         end
      end
   end
   initial bus_b.out_ready = 1'b1;

   // ---------------- monitor A
   bit          hold_a = 1'b0;
   logic [63:0] hd_a;
   logic [1:0]  hcore_a;
   logic [2:0]  haddr_a;
   always @(negedge clk) begin
      if (!rst_a) begin
         hold_a = 1'b0;
      end else begin
         if (bus_a.dump_en || bus_a.out_valid)
            chk("a_excl", 64'(bus_a.dump_en & bus_a.out_valid), 64'd0);
         if (hold_a) begin
            chk("a_hold_valid", 64'(bus_a.out_valid), 64'd1);
            chk("a_hold_data", bus_a.out_data, hd_a);
            chk("a_hold_core", 64'(bus_a.out_core), 64'(hcore_a));
            chk("a_hold_addr", 64'(bus_a.out_addr), 64'(haddr_a));
         end
         hold_a  = bus_a.out_valid && !bus_a.out_ready;
         hd_a    = bus_a.out_data;
         hcore_a = bus_a.out_core;
         haddr_a = bus_a.out_addr;
         if (bus_a.out_valid && bus_a.out_ready) begin
            if (qa.size() == 0) begin
               chk("a_unexpected_word", 64'd1, 64'd0);
            end else begin
               wa = qa.pop_front();
               chk("a_word_data", bus_a.out_data, wa.data);
               chk("a_word_core", 64'(bus_a.out_core), 64'(wa.core));
               chk("a_word_addr", 64'(bus_a.out_addr), 64'(wa.addr));
            end
         end
      end
   end

   // ---------------- monitor B (out_ready always 1: 3 cycles per word)
   int b_prev = -1;
   always @(negedge clk) begin
      if (rst_b) begin
         if (bus_b.dump_en || bus_b.out_valid)
            chk("b_excl", 64'(bus_b.dump_en & bus_b.out_valid), 64'd0);
         if (bus_b.out_valid && bus_b.out_ready) begin
            if (b_prev >= 0) chk("b_word_spacing", 64'(cyc - b_prev), 64'd3);
            b_prev = cyc;
            if (qb.size() == 0) begin
               chk("b_unexpected_word", 64'd1, 64'd0);
            end else begin
               wb = qb.pop_front();
               chk("b_word_data", bus_b.out_data, wb.data);
               chk("b_word_addr", 64'(bus_b.out_addr), 64'(wb.addr));
            end
         end
      end
   end

   task automatic push_a();
      for (int c = 0; c < 4; c++)
         for (int a = 0; a < 8; a++) qa.push_back('{c, a, pat(c, a)});
   endtask

   task automatic push_b();
      for (int a = 0; a < 128; a++) qb.push_back('{0, a, pat(0, a)});
   endtask

   // count negedges from "all halted visible" to the dump read strobe
   task automatic drain_len_a();
      int n = 0;
      do begin @(negedge clk); n++; end while (!bus_a.dump_en && n < 50);
      chk("a_drain_to_dump", 64'(n), 64'd6);
   endtask

   task automatic run_a(input int h0, input int h1, input int h2, input int h3, input int restart_at);
      int h[4];
      int maxh;
      h = '{h0, h1, h2, h3};
      maxh = 0;
      for (int i = 0; i < 4; i++) if (h[i] > maxh) maxh = h[i];
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      for (int k = 0; k <= maxh; k++) begin
         start_a = (k == restart_at);
         for (int i = 0; i < 4; i++) begin
            iv_a[i] = 1'b1;
            inst_a[i*32 +: 32] = (k == h[i]) ? 32'h0 : NOP;
         end
         if (k == h[0] - 3) begin iv_a[0] = 1'b0; inst_a[31:0] = 32'h0; end
         if (k == h[0] + 2) inst_a[31:0] = 32'h0;
         if (k > h[1]) inst_a[63:32] = 32'h0;
         if (restart_at >= 0 && k == restart_at + 1) begin
            @(negedge clk);
            chk("a_start_ignored_in_run", 64'(tot_a), 64'(k));
         end
         tick();
      end
      start_a = 1'b0;
      iv_a = '0;
      for (int i = 0; i < 4; i++) inst_a[i*32 +: 32] = NOP;
      @(negedge clk);
      chk("a_halted", 64'(halted_a), 64'hF);
      for (int i = 0; i < 4; i++) chk($sformatf("a_halt_cycle%0d", i), 64'(hc_a[i*32 +: 32]), 64'(h[i]));
      chk("a_total_cycles", 64'(tot_a), 64'(maxh + 1));
      chk("a_busy_run", 64'(busy_a), 64'd1);
      drain_len_a();
      chk("a_total_frozen", 64'(tot_a), 64'(maxh + 1));
   endtask

   task automatic run_b(input int h, input int exp_hc, input int exp_tot);
      int n = 0;
      b_prev = -1;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int k = 0; k <= h; k++) begin
         iv_b = 1'b1;
         inst_b = (k == h) ? 32'h0 : NOP;
         tick();
      end
      iv_b = 1'b0;
      inst_b = NOP;
      @(negedge clk);
      chk("b_halted", 64'(halted_b), 64'd1);
      chk("b_halt_cycle", 64'(hc_b), 64'(exp_hc));
      chk("b_total_cycles", 64'(tot_b), 64'(exp_tot));
      do begin @(negedge clk); n++; end while (!bus_b.dump_en && n < 50);
      chk("b_drain_to_dump", 64'(n), 64'd6);
   endtask

   task automatic wait_done_a(input int budget);
      int n = 0;
      while (!done_a && n < budget) begin @(negedge clk); n++; end
      chk("a_done", 64'(done_a), 64'd1);
      chk("a_busy_done", 64'(busy_a), 64'd0);
      chk("a_queue_empty", 64'(qa.size()), 64'd0);
      tick();
   endtask

   task automatic wait_done_b(input int budget);
      int n = 0;
      while (!done_b && n < budget) begin @(negedge clk); n++; end
      chk("b_done", 64'(done_b), 64'd1);
      chk("b_queue_empty", 64'(qb.size()), 64'd0);
      tick();
   endtask

   task automatic chk_idle_a(input string tag);
      chk({tag, "_busy"}, 64'(busy_a), 64'd0);
      chk({tag, "_done"}, 64'(done_a), 64'd0);
      chk({tag, "_halted"}, 64'(halted_a), 64'd0);
      chk({tag, "_halt_cycle"}, 64'(hc_a[127:64] | hc_a[63:0]), 64'd0);
      chk({tag, "_total"}, 64'(tot_a), 64'd0);
      chk({tag, "_out_valid"}, 64'(bus_a.out_valid), 64'd0);
      chk({tag, "_dump_en"}, 64'(bus_a.dump_en), 64'd0);
      chk({tag, "_out_data"}, bus_a.out_data, 64'd0);
      chk({tag, "_out_tag"}, 64'({bus_a.out_core, bus_a.out_addr, bus_a.dump_core, bus_a.dump_addr}), 64'd0);
   endtask

   initial begin
      int n;
      repeat (3) tick();
      chk_idle_a("a_reset");
      chk("b_reset_busy", 64'(busy_b), 64'd0);
      chk("b_reset_total", 64'(tot_b), 64'd0);
      rst_a = 1'b1;
      rst_b = 1'b1;
      tick();

      // single core: halt at 10, then counter saturation with halt at 20
      push_b();
      run_b(10, 10, 11);
      wait_done_b(1000);
      push_b();
      run_b(20, 15, 15);
      wait_done_b(1000);

      // four cores with random backpressure and a long stall
      a_rand = 1'b1;
      push_a();
      run_a(7, 3, 12, 12, -1);
      wait_done_a(3000);

      // reset while a word is presented; start during RUN is ignored
      a_rand = 1'b0;
      a_ready_const = 1'b0;
      run_a(5, 5, 5, 5, 3);
      n = 0;
      while (!bus_a.out_valid && n < 40) begin @(negedge clk); n++; end
      chk("a_word_presented", 64'(bus_a.out_valid), 64'd1);
      repeat (3) tick();
      rst_a = 1'b0;
      #1;
      chk_idle_a("a_abort");
      qa.delete();
      tick();
      rst_a = 1'b1;
      tick();

      // clean repeat run after the abort
      a_ready_const = 1'b1;
      push_a();
      run_a(6, 1, 2, 4, -1);
      wait_done_a(3000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end
endmodule
